// File: rtl/axi4_mem_pkg.sv
// Shared types and helpers for the two-port AXI4 slave memory.
package axi4_mem_pkg;

  typedef enum logic {S_INIT, S_RUN} mem_state_e;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  // Per-lane strobe merge; callers loop over byte lanes so any DATA_WIDTH works.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       strb);
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/axi4_mem_rd_pipe.sv
// Read-return register chain: STAGES deep, data advances only with valid, flushed on rst.
module axi4_mem_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [STAGES-1:0]     r_valid;
  logic [DATA_WIDTH-1:0] r_data [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < STAGES; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      if (i_valid) r_data[0] <= i_data;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        if (r_valid[i-1]) r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[STAGES-1];
  assign o_data  = r_data[STAGES-1];

endmodule

// File: rtl/axi4_mem_2p.sv
// Two-port (1W + 1R) byte-strobed memory with optional post-reset zeroing sequencer.
module axi4_mem_2p
  import axi4_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned RDW_MODE      = 0,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  mem_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_init_busy;

  logic                  w_run;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic [DATA_WIDTH-1:0] w_wr_old;
  logic [DATA_WIDTH-1:0] w_wr_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_run         = (r_state == S_RUN);
  assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign w_wr_ok       = w_run && wr_en && w_wr_in_range;
  assign w_rd_ok       = w_run && rd_en;

  // The merged write word doubles as the forwarded read word for same-address RDW.
  always_comb begin
    w_wr_old    = w_wr_in_range ? r_mem[wr_addr] : '0;
    w_wr_merged = w_wr_old;
    for (int unsigned i = 0; i < STRB_WIDTH; i++)
      w_wr_merged[8*i +: 8] = byte_merge(w_wr_old[8*i +: 8], wr_data[8*i +: 8], wr_strb[i]);
    w_rd_word = '0;
    if (w_rd_in_range) begin
      if (RDW_MODE == RDW_NEW && w_wr_ok && wr_addr == rd_addr) w_rd_word = w_wr_merged;
      else                                                      w_rd_word = r_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
      r_init_cnt  <= '0;
      r_init_busy <= (INIT_ON_RESET != 0);
    end else if (r_state == S_INIT) begin
      if (r_init_cnt == LAST_ADDR) begin
        r_state     <= S_RUN;
        r_init_busy <= 1'b0;
      end else begin
        r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_INIT) r_mem[r_init_cnt] <= '0;
      else if (w_wr_ok)      r_mem[wr_addr]    <= w_wr_merged;
    end
  end

  axi4_mem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_rd_ok),
    .i_data  (w_rd_word),
    .o_valid (rd_valid),
    .o_data  (rd_data)
  );

  assign init_busy = r_init_busy;

endmodule
